// File: rtl/ram_arbiter.sv
// Two-port arbiter (Z80 CPU and loader) for one synchronous 8-bit RAM, one access per four-cycle slot.
// Optional loader anti-starvation counter enabled by defining RAM_ARB_FAIRNESS_EN.
module ram_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_wdata,
   output logic [7:0]        ld_rdata,
   output logic              ld_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t state, state_nx;
   logic   owner_ld;
   logic   lat_we;
   logic   grant;
   logic   grant_ld;
   logic   ld_wins;

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("STARVE_MAX must be at least 1");
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_ld = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req || ld_req) begin
               grant    = 1'b1;
               grant_ld = ld_req && (!cpu_req || ld_wins);
               state_nx = ACCESS;
            end
         end
         ACCESS:  state_nx = WAIT;
         WAIT:    state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The granted request is latched once, so a requester dropping req mid-access changes nothing.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         owner_ld  <= 1'b0;
         lat_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_rdata <= '0;
         ld_rdata  <= '0;
      end else begin
         if (grant) begin
            owner_ld  <= grant_ld;
            lat_we    <= grant_ld ? ld_we    : cpu_we;
            ram_addr  <= grant_ld ? ld_addr  : cpu_addr;
            ram_wdata <= grant_ld ? ld_wdata : cpu_wdata;
         end
         if (state == DONE && !lat_we) begin
            if (owner_ld) ld_rdata  <= ram_rdata;
            else          cpu_rdata <= ram_rdata;
         end
      end
   end

`ifdef RAM_ARB_FAIRNESS_EN
   localparam int                  STREAK_W   = $clog2(STARVE_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

   logic [STREAK_W-1:0] streak;

   assign ld_wins = (streak == STREAK_MAX);

   // Counts CPU wins while the loader is waiting; once saturated the loader takes the next slot.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         streak <= '0;
      end else if (state == IDLE) begin
         if (grant && grant_ld)
            streak <= '0;
         else if (!ld_req)
            streak <= '0;
         else if (grant && streak != STREAK_MAX)
            streak <= streak + 1'b1;
      end
   end
`else
   assign ld_wins = 1'b0;
`endif

   assign ram_we   = (state == ACCESS) && lat_we;
   assign cpu_ack  = (state == DONE) && !owner_ld;
   assign ld_ack   = (state == DONE) && owner_ld;
   assign busy     = (state != IDLE);
   assign cpu_wait = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Expectations for the fairness case follow RAM_ARB_FAIRNESS_EN.
module tb_ram_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, ld_req, ld_we;
   logic [13:0] cpu_addr, ld_addr;
   logic [7:0]  cpu_wdata, ld_wdata;
   logic [7:0]  cpu_rdata, ld_rdata, ram_wdata, ram_rdata;
   logic        cpu_ack, cpu_wait, ld_ack, ram_we, busy;
   logic [13:0] ram_addr;

   logic [7:0]  mem [0:16383];

   int compared   = 0;
   int mismatched = 0;

   ram_arbiter #(.ADDR_W(14), .STARVE_MAX(4)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_rdata(ld_rdata), .ld_ack(ld_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic applyStimulus(input logic cr, input logic cwe, input logic [13:0] ca,
                                input logic [7:0] cd, input logic lr, input logic lwe,
                                input logic [13:0] la, input logic [7:0] ld);
      cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
      ld_req  = lr; ld_we  = lwe; ld_addr  = la; ld_wdata  = ld;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk_sys);
      #1;
   endtask

   int cpuAckCyc, ldAckCyc, bothAcks, cpuAcks, ldAcks;
   bit cpuDrop, ldDrop;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      mem[14'h0123] = 8'h5A;
      reset = 1'b1;
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);

      // Reset state
      @(negedge clk_sys);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_acks", {cpu_ack, ld_ack, ram_we}, 0);
      checkOutput("rst_ram_addr", ram_addr, 0);
      checkOutput("rst_rdata", {cpu_rdata, ld_rdata, ram_wdata}, 0);
      nextCycle();
      reset = 1'b0;

      // CPU read of 0x0123
      applyStimulus(1, 0, 14'h0123, 8'h00, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("rd_c0_wait", cpu_wait, 1);
      checkOutput("rd_c0_ack", cpu_ack, 0);
      nextCycle(); @(negedge clk_sys);
      checkOutput("rd_c1_busy", busy, 1);
      checkOutput("rd_c1_addr", ram_addr, 14'h0123);
      checkOutput("rd_c1_we", ram_we, 0);
      checkOutput("rd_c1_wait", cpu_wait, 1);
      nextCycle(); @(negedge clk_sys);
      checkOutput("rd_c2_ack", cpu_ack, 0);
      checkOutput("rd_c2_wait", cpu_wait, 1);
      nextCycle(); @(negedge clk_sys);
      checkOutput("rd_c3_ack", {cpu_ack, ld_ack}, 2'b10);
      checkOutput("rd_c3_wait", cpu_wait, 0);
      checkOutput("rd_c3_we", ram_we, 0);
      nextCycle();
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("rd_c4_rdata", cpu_rdata, 8'h5A);
      checkOutput("rd_c4_busy", busy, 0);

      // Loader write of 0xC3 to 0x3FFF
      nextCycle();
      applyStimulus(0, 0, 14'h0, 8'h0, 1, 1, 14'h3FFF, 8'hC3);
      @(negedge clk_sys);
      checkOutput("wr_c0_we", ram_we, 0);
      nextCycle(); @(negedge clk_sys);
      checkOutput("wr_c1_we", ram_we, 1);
      checkOutput("wr_c1_addr", ram_addr, 14'h3FFF);
      checkOutput("wr_c1_wdata", ram_wdata, 8'hC3);
      nextCycle(); @(negedge clk_sys);
      checkOutput("wr_c2_we", ram_we, 0);
      checkOutput("wr_c2_ack", ld_ack, 0);
      nextCycle(); @(negedge clk_sys);
      checkOutput("wr_c3_ack", {cpu_ack, ld_ack}, 2'b01);
      nextCycle();
      applyStimulus(1, 0, 14'h3FFF, 8'h00, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("wr_ld_rdata_kept", ld_rdata, 8'h00);
      nextCycle(); nextCycle(); nextCycle(); @(negedge clk_sys);
      checkOutput("rb_c3_ack", cpu_ack, 1);
      nextCycle();
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("rb_rdata", cpu_rdata, 8'hC3);

      // Simultaneous requests: CPU first, loader four cycles later
      nextCycle();
      applyStimulus(1, 0, 14'h0123, 8'h0, 1, 0, 14'h3FFF, 8'h0);
      cpuAckCyc = -1; ldAckCyc = -1; bothAcks = 0; cpuDrop = 0; ldDrop = 0;
      for (int c = 0; c < 12; c++) begin
         if (cpuDrop) cpu_req = 1'b0;
         if (ldDrop)  ld_req  = 1'b0;
         @(negedge clk_sys);
         if (cpu_ack && ld_ack) bothAcks++;
         if (cpu_ack) begin cpuAckCyc = c; cpuDrop = 1; end
         if (ld_ack)  begin ldAckCyc  = c; ldDrop  = 1; end
         nextCycle();
      end
      checkOutput("sim_cpu_ack_cyc", cpuAckCyc, 3);
      checkOutput("sim_ld_ack_cyc", ldAckCyc, 7);
      checkOutput("sim_both_acks", bothAcks, 0);
      checkOutput("sim_ld_rdata", ld_rdata, 8'hC3);
      checkOutput("sim_cpu_rdata", cpu_rdata, 8'h5A);

      // CPU back-to-back with loader waiting
      applyStimulus(1, 0, 14'h0010, 8'h0, 1, 0, 14'h0123, 8'h0);
      ldAckCyc = -1; cpuAcks = 0; ldAcks = 0; ldDrop = 0;
      for (int c = 0; c < 100; c++) begin
         if (ldDrop) ld_req = 1'b0;
         @(negedge clk_sys);
         if (cpu_ack && ldAcks == 0) cpuAcks++;
         if (ld_ack) begin
            if (ldAcks == 0) ldAckCyc = c;
            ldAcks++;
            ldDrop = 1;
         end
         nextCycle();
      end
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);
`ifdef RAM_ARB_FAIRNESS_EN
      checkOutput("fair_cpu_acks_first", cpuAcks, 4);
      checkOutput("fair_ld_ack_cyc", ldAckCyc, 19);
      checkOutput("fair_ld_rdata", ld_rdata, 8'h5A);
`else
      checkOutput("nofair_ld_acks", ldAcks, 0);
      checkOutput("nofair_cpu_acks", cpuAcks, 25);
`endif
      for (int c = 0; c < 6; c++) nextCycle();

      // Reset pulsed in WAIT of a CPU read
      applyStimulus(1, 0, 14'h3FFF, 8'h0, 0, 0, 14'h0, 8'h0);
      nextCycle(); nextCycle();
      reset = 1'b1;
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("rstw_ctrl", {busy, cpu_ack, ld_ack, ram_we, cpu_wait}, 0);
      checkOutput("rstw_ram", {ram_addr, ram_wdata}, 0);
      checkOutput("rstw_rdata", {cpu_rdata, ld_rdata}, 0);
      nextCycle(); @(negedge clk_sys);
      checkOutput("rstw_c3_ack", {cpu_ack, busy}, 0);
      nextCycle();
      reset = 1'b0;
      @(negedge clk_sys);
      checkOutput("rstw_rel_ack", cpu_ack, 0);
      nextCycle();
      applyStimulus(1, 0, 14'h0123, 8'h0, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("post_c0_wait", cpu_wait, 1);
      nextCycle(); @(negedge clk_sys);
      checkOutput("post_c1_addr", ram_addr, 14'h0123);
      nextCycle(); @(negedge clk_sys);
      checkOutput("post_c2_ack", cpu_ack, 0);
      nextCycle(); @(negedge clk_sys);
      checkOutput("post_c3_ack", cpu_ack, 1);
      nextCycle();
      applyStimulus(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0);
      @(negedge clk_sys);
      checkOutput("post_rdata", cpu_rdata, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
